ram_seq_reader: RTL
===================

Name: ram_seq_reader

Overview:
- Read-side controller for the single-port pattern RAM. On a start pulse it sweeps an address range and drives the RAM read-enable and address, one word per cycle.
- From each returned word it extracts one bit (bit 3 by default) into a serial stream.
- It runs an overlapping "001" detector on that stream, reporting each hit with its address and a running match count.
- It sits between the RAM and the top-level detector interface and never writes the RAM.

Parameters:
- ADDR_W, 5, RAM address width; the sweep wraps modulo 2^ADDR_W.
- DATA_W, 8, RAM word width.
- BIT_SEL, 3, index of the data bit fed to the detector; must be less than DATA_W.
- CNT_W, 8, width of match_count.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- start_addr  in  ADDR_W  first address of the sweep; sampled on the accepting edge.
- end_addr  in  ADDR_W  last address of the sweep, inclusive; sampled on the accepting edge.
- mem_en_read  out  1  RAM read enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_data  in  DATA_W  RAM data_out; valid one cycle after the address is presented.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at end of sweep.
- detect  out  1  one-cycle pulse per "001" match.
- detect_addr  out  ADDR_W  address of the word that supplied the terminating '1'; updated on each detect.
- match_count  out  CNT_W  matches in the current or last sweep; saturates at all-ones.

Behaviour:
- Reset:
  - Asynchronous and immediate: all outputs 0, FSM to IDLE, detector to S0, internal pipeline valid flag cleared.
  - Reset mid-sweep aborts the sweep with no done pulse.
- Control FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - mem_en_read=0 and busy=0.
  - start=1 latches start_addr and end_addr, clears match_count, sets the detector to S0, then goes to RUN.
- RUN:
  - busy=1, mem_en_read=1, mem_addr = current address.
  - The address increments by 1 each cycle, modulo 2^ADDR_W.
  - When mem_addr == end_addr, go to DRAIN next.
  - end_addr < start_addr wraps through the maximum address and 0.
  - start_addr == end_addr gives exactly one word.
  - A full-range sweep is not expressible and needs two requests.
- DRAIN: busy=1, mem_en_read=0; the word for the last address is sampled this cycle.
- DONE: busy=0, done=1 for one cycle, then IDLE.
- start while not in IDLE is ignored.
- Read pipeline:
  - Address A is issued in cycle t. mem_data holds mem[A] in cycle t+1 and is sampled at the end of t+1.
  - detect and detect_addr=A are registered and visible in cycle t+2, a latency of 2 from address issue.
  - A valid flag delayed by one cycle gates sampling, so the first RUN cycle samples nothing.
- Detector (Moore, overlapping), input b = mem_data[BIT_SEL]:
  - S0: b=0 -> S1; b=1 -> S0.
  - S1: b=0 -> S2; b=1 -> S0.
  - S2: b=0 -> S2; b=1 -> S0 with a detect pulse.
  - The detector state is not carried between sweeps; each start resets it to S0.
- match_count increments by 1 on each detect and holds at 2^CNT_W-1.
- match_count and detect_addr hold their values after done until the next accepted start.
- A final-word detect and done coincide in the DONE cycle.
- mem_addr holds its last value outside RUN. The block never drives write enable.

Optional Feature:
- Macro: STOP_ON_FIRST_EN.
- When defined:
  - The first detect aborts the sweep: the FSM goes straight to DONE on the cycle detect is raised.
  - done pulses in the following cycle, then IDLE. At most one match is counted.
  - Any read already issued is discarded, and mem_en_read is low from the cycle detect is high.
- When undefined: the full range is always swept and all matches are counted.

Test Plan:
- Data bit3 over addresses 0..5 = 0,0,1,0,0,1 (words 0x00,0x00,0x08,0x00,0x00,0x08); start_addr=0, end_addr=5 -> detect pulses with detect_addr=2 then 5, match_count=2, done 8 cycles after start was accepted, busy high for 7 cycles.
- Bits 0,0,0,1,0,0,0,1 over addresses 0..7 -> hits at addresses 3 and 7 (the S2 self-loop), match_count=2. The same data read from bit 2 instead of bit 3 (e.g. words 0x04 vs 0x08) -> no detect.
- Wrap: start_addr=30, end_addr=1; bits at 30,31,0,1 = 0,0,1,1 -> mem_addr sequence 30,31,0,1, one detect with detect_addr=0, match_count=1.
- Single word: start_addr=end_addr=7 -> one RUN cycle, no detect, done pulse, match_count=0. A start pulse while busy -> ignored, the sweep is unaffected.
- Assert rst for one cycle mid-sweep -> all outputs 0 immediately, no done pulse. A new start afterwards runs cleanly from S0.
- With CNT_W=2 and 5 matches -> match_count=3. With STOP_ON_FIRST_EN on the first test's data -> single detect at address 2, match_count=1, done pulse, no reads beyond address 3.

Source files
------------

// File: rtl/ram_seq_reader.sv
`default_nettype none
// ============================================================================
// Module  : ram_seq_reader
// Purpose : Sweeps a RAM address range, feeds one bit per word into an
//           overlapping "001" detector. Optional macro: STOP_ON_FIRST_EN.
// Revision: 1.0 - initial release
// ============================================================================
module ram_seq_reader #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int BIT_SEL = 3,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              mem_en_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              done,
  output logic              detect,
  output logic [ADDR_W-1:0] detect_addr,
  output logic [CNT_W-1:0]  match_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] DET_S0 = 2'd0;
  localparam logic [1:0] DET_S1 = 2'd1;
  localparam logic [1:0] DET_S2 = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [1:0]        r_det_state;
  logic [1:0]        w_det_nxt;
  logic [ADDR_W-1:0] r_end_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_valid;
  logic              w_accept;
  logic              w_last_addr;
  logic              w_abort;
  logic              w_sample;
  logic              w_bit;
  logic              w_hit;
  logic              w_unused_data;

  assign w_accept    = (r_state == ST_IDLE) && start;
  assign w_last_addr = (mem_addr == r_end_addr);
  assign w_bit       = mem_data[BIT_SEL];
  assign w_unused_data = ^mem_data;

`ifdef STOP_ON_FIRST_EN
  // A raised detect kills the sweep and discards the read still in flight.
  assign w_abort = detect;
`else
  assign w_abort = 1'b0;
`endif

  assign w_sample = r_rd_valid && !w_abort;
  assign w_hit    = w_sample && (r_det_state == DET_S2) && w_bit;

  // Control FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Control FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_abort)          w_state_nxt = ST_DONE;
        else if (w_last_addr) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Control FSM: outputs
  always_comb begin
    busy        = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    done        = (r_state == ST_DONE);
    mem_en_read = (r_state == ST_RUN) && !w_abort;
  end

  // Address generator; holds on the final address so mem_addr keeps it after RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr   <= '0;
      r_end_addr <= '0;
    end else if (w_accept) begin
      mem_addr   <= start_addr;
      r_end_addr <= end_addr;
    end else if ((r_state == ST_RUN) && !w_last_addr) begin
      mem_addr <= mem_addr + 1'b1;
    end
  end

  // Read pipeline: tags the word that arrives on mem_data next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_addr  <= '0;
    end else begin
      r_rd_valid <= mem_en_read;
      r_rd_addr  <= mem_addr;
    end
  end

  always_comb begin
    w_det_nxt = r_det_state;
    case (r_det_state)
      DET_S0:  w_det_nxt = w_bit ? DET_S0 : DET_S1;
      DET_S1:  w_det_nxt = w_bit ? DET_S0 : DET_S2;
      DET_S2:  w_det_nxt = w_bit ? DET_S0 : DET_S2;
      default: w_det_nxt = DET_S0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_det_state <= DET_S0;
    end else if (w_accept) begin
      r_det_state <= DET_S0;
    end else if (w_sample) begin
      r_det_state <= w_det_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      detect      <= 1'b0;
      detect_addr <= '0;
      match_count <= '0;
    end else begin
      detect <= w_hit;
      if (w_hit) detect_addr <= r_rd_addr;
      if (w_accept) begin
        match_count <= '0;
      end else if (w_hit && !(&match_count)) begin
        match_count <= match_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
